// File: rtl/bus_handshakes_pipe_slice_if.sv
// bus_handshakes_pipe_slice_if: upstream/downstream handshake bundle with flush and occupancy
interface bus_handshakes_pipe_slice_if #(
    parameter int WIDTH = 9,
    parameter int STAGES = 2
);
    localparam int OW = $clog2(2 * STAGES + 1);
    logic flush;
    logic src_vaild;
    logic src_ready;
    logic [WIDTH-1:0] src_data_in;
    logic dst_vaild;
    logic dst_ready;
    logic [WIDTH-1:0] dst_data_out;
    logic [OW-1:0] occupancy;
    modport slave (
        input flush, src_vaild, src_data_in, dst_ready,
        output src_ready, dst_vaild, dst_data_out, occupancy
    );
    modport master (
        output flush, src_vaild, src_data_in, dst_ready,
        input src_ready, dst_vaild, dst_data_out, occupancy
    );
endinterface

// File: rtl/bus_handshakes_pipe_slice.sv
// bus_handshakes_pipe_slice: cascade of valid/ready register slices, selectable wire/forward/backward/full mode
module bus_handshakes_pipe_slice #(
    parameter int WIDTH = 9,
    parameter int STAGES = 2,
    parameter int MODE = 3
) (
    input logic clk,
    input logic s_rst,
    bus_handshakes_pipe_slice_if.slave bus
);
    localparam int OW = $clog2(2 * STAGES + 1);
    typedef enum logic [1:0] {EMPTY = 2'b00, ONE = 2'b01, TWO = 2'b11} state_t;

    logic [STAGES:0] v;
    logic [STAGES:0] r;
    logic [STAGES:0][WIDTH-1:0] d;
    logic [STAGES-1:0][1:0] cnt;

    assign v[0] = bus.src_vaild;
    assign d[0] = bus.src_data_in;
    assign bus.src_ready = r[0];
    assign bus.dst_vaild = v[STAGES];
    assign bus.dst_data_out = d[STAGES];
    assign r[STAGES] = bus.dst_ready;

    always_comb begin
        bus.occupancy = '0;
        for (int i = 0; i < STAGES; i++) bus.occupancy = bus.occupancy + OW'(cnt[i]);
    end

    for (genvar i = 0; i < STAGES; i++) begin : g_stage
        if (MODE == 0) begin : g_wire
            assign v[i+1] = v[i];
            assign d[i+1] = d[i];
            assign r[i] = r[i+1];
            assign cnt[i] = 2'd0;
        end else if (MODE == 1) begin : g_fwd
            logic full;
            logic rst_q;
            logic [WIDTH-1:0] data;
            // ready just follows downstream while coming out of reset
            assign r[i] = (s_rst || rst_q) ? r[i+1] : (r[i+1] || !full);
            assign v[i+1] = full;
            assign d[i+1] = data;
            assign cnt[i] = {1'b0, full};
            always_ff @(posedge clk) begin
                rst_q <= s_rst;
                if (s_rst) begin
                    full <= 1'b0;
                    data <= '0;
                end else if (bus.flush) begin
                    full <= 1'b0;
                end else if (r[i]) begin
                    full <= v[i];
                    if (v[i]) data <= d[i];
                end
            end
        end else if (MODE == 2) begin : g_bwd
            logic skid_v;
            logic rdy;
            logic nxt;
            logic [WIDTH-1:0] skid;
            assign r[i] = rdy;
            assign v[i+1] = skid_v || (v[i] && rdy);
            assign d[i+1] = skid_v ? skid : d[i];
            assign cnt[i] = {1'b0, skid_v};
            assign nxt = skid_v ? !r[i+1] : (v[i] && rdy && !r[i+1]);
            always_ff @(posedge clk) begin
                skid_v <= !s_rst && !bus.flush && nxt;
                rdy <= !s_rst && (bus.flush || !nxt);
                if (!skid_v && v[i] && rdy && !r[i+1]) skid <= d[i];
            end
        end else begin : g_full
            state_t state;
            state_t state_n;
            logic rdy;
            logic acc;
            logic [WIDTH-1:0] main;
            logic [WIDTH-1:0] skid;
            assign acc = v[i] && rdy;
            assign r[i] = rdy;
            assign v[i+1] = state[0];
            assign d[i+1] = main;
            assign cnt[i] = state[1] ? 2'd2 : {1'b0, state[0]};
            always_comb begin
                state_n = (s_rst || bus.flush) ? EMPTY :
                          (state == EMPTY) ? (acc ? ONE : EMPTY) :
                          (state == ONE) ? ((acc == r[i+1]) ? ONE : (acc ? TWO : EMPTY)) :
                          (r[i+1] ? ONE : TWO);
            end
            // ready is registered from the next state so it never depends on downstream combinationally
            always_ff @(posedge clk) begin
                state <= state_n;
                rdy <= !s_rst && state_n != TWO;
                if (s_rst) main <= '0;
                else if (state == TWO ? r[i+1] : acc && (state == EMPTY || r[i+1])) main <= (state == TWO) ? skid : d[i];
                if (state == ONE && acc && !r[i+1]) skid <= d[i];
            end
        end
    end
endmodule

// File: tb/tb_bus_handshakes_pipe_slice.sv
// tb_bus_handshakes_pipe_slice: directed vectors and a random scoreboard run over four slice configurations
module tb_bus_handshakes_pipe_slice;
    logic clk = 1'b0;
    logic s_rst = 1'b1;
    logic rnd = 1'b0;
    logic sv [4];
    logic dr [4];
    logic fl [4];
    logic [8:0] sd [4];
    logic stall_a [4];
    int dn_a [4];
    int pn_a [4];
    int n_chk = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // k: 0 = full/2 stages, 1 = forward/3, 2 = backward/1, 3 = wires/4
    for (genvar k = 0; k < 4; k++) begin : g
        localparam int MD = (k == 0) ? 3 : (k == 1) ? 1 : (k == 2) ? 2 : 0;
        localparam int ST = (k == 0) ? 2 : (k == 1) ? 3 : (k == 2) ? 1 : 4;
        localparam int CAP = (MD == 3) ? 2 * ST : (MD == 0) ? 0 : ST;
        bus_handshakes_pipe_slice_if #(.WIDTH(9), .STAGES(ST)) bus ();
        bus_handshakes_pipe_slice #(.WIDTH(9), .STAGES(ST), .MODE(MD)) dut (
            .clk(clk),
            .s_rst(s_rst),
            .bus(bus)
        );
        assign bus.flush = fl[k];
        assign bus.src_vaild = sv[k];
        assign bus.src_data_in = sd[k];
        assign bus.dst_ready = dr[k];
        logic [8:0] q [$];
        logic stall = 1'b0;
        logic hold = 1'b0;
        logic [8:0] pd = '0;
        int dn = 0;
        int pn = 0;
        assign stall_a[k] = stall;
        assign dn_a[k] = dn;
        assign pn_a[k] = pn;
        always @(negedge clk) begin
            if (rnd) begin
                check($sformatf("m%0d_occ", MD), 32'(bus.occupancy), q.size());
                check($sformatf("m%0d_cap", MD), 32'(bus.occupancy <= CAP), 1);
                if (hold) begin
                    check($sformatf("m%0d_hold_vld", MD), 32'(bus.dst_vaild), 1);
                    check($sformatf("m%0d_hold_data", MD), 32'(bus.dst_data_out), 32'(pd));
                end
                hold = bus.dst_vaild && !bus.dst_ready;
                pd = bus.dst_data_out;
                stall = bus.src_vaild && !bus.src_ready;
                if (bus.src_vaild && bus.src_ready) q.push_back(bus.src_data_in);
                if (bus.dst_vaild && bus.dst_ready) begin
                    check($sformatf("m%0d_nonempty", MD), 32'(q.size() > 0), 1);
                    if (q.size() > 0) begin
                        check($sformatf("m%0d_order", MD), 32'(bus.dst_data_out), 32'(q.pop_front()));
                        dn++;
                    end
                end
                pn = q.size();
            end
        end
    end

    initial begin
        int n;
        int m;
        int c;
        for (int k = 0; k < 4; k++) begin
            sv[k] = 1'b0;
            dr[k] = 1'b0;
            fl[k] = 1'b0;
            sd[k] = '0;
        end
        dr[1] = 1'b1;
        // reset and the first cycle after it
        repeat (2) tick();
        s_rst = 1'b0;
        #1;
        check("rst_vld", 32'(g[0].bus.dst_vaild), 0);
        check("rst_occ", 32'(g[0].bus.occupancy), 0);
        check("rst_data", 32'(g[0].bus.dst_data_out), 0);
        check("rst_rdy_m3", 32'(g[0].bus.src_ready), 0);
        check("rst_rdy_m2", 32'(g[2].bus.src_ready), 0);
        check("rst_rdy_m1", 32'(g[1].bus.src_ready), 1);
        check("rst_rdy_m0", 32'(g[3].bus.src_ready), 0);
        tick();
        #1;
        check("rst_rdy_m3_after", 32'(g[0].bus.src_ready), 1);
        check("rst_rdy_m2_after", 32'(g[2].bus.src_ready), 1);
        dr[1] = 1'b0;
        // full mode, back-to-back stream with downstream always ready
        dr[0] = 1'b1;
        for (int i = 0; i < 20; i++) begin
            sv[0] = (i < 16);
            sd[0] = 9'(i + 1);
            #1;
            check("t31_vld", 32'(g[0].bus.dst_vaild), 32'(i >= 2 && i <= 17));
            if (i >= 2 && i <= 17) check("t31_data", 32'(g[0].bus.dst_data_out), i - 1);
            check("t31_occ", 32'(g[0].bus.occupancy), (i < 2) ? i : (i <= 16) ? 2 : (i <= 18) ? 18 - i : 0);
            check("t31_rdy", 32'(g[0].bus.src_ready), 1);
            tick();
        end
        // full mode, downstream stalled then released
        dr[0] = 1'b0;
        n = 0;
        for (int i = 0; i < 8; i++) begin
            sv[0] = 1'b1;
            sd[0] = 9'(32'h0A0 + n);
            #1;
            if (g[0].bus.src_ready) n++;
            tick();
        end
        #1;
        check("t32_acc", n, 4);
        check("t32_rdy", 32'(g[0].bus.src_ready), 0);
        check("t32_occ", 32'(g[0].bus.occupancy), 4);
        dr[0] = 1'b1;
        m = 0;
        for (int i = 0; i < 30 && m < 8; i++) begin
            sv[0] = (n < 8);
            sd[0] = 9'(32'h0A0 + n);
            #1;
            if (g[0].bus.dst_vaild) begin
                check("t32_data", 32'(g[0].bus.dst_data_out), 32'h0A0 + m);
                m++;
            end
            if (sv[0] && g[0].bus.src_ready) n++;
            tick();
        end
        sv[0] = 1'b0;
        check("t32_cnt", m, 8);
        // forward mode, flush with a full pipe and a word on the input
        for (int i = 0; i < 3; i++) begin
            sv[1] = 1'b1;
            sd[1] = 9'(32'h010 + i);
            tick();
        end
        #1;
        check("t34_occ", 32'(g[1].bus.occupancy), 3);
        check("t34_full", 32'(g[1].bus.src_ready), 0);
        fl[1] = 1'b1;
        sd[1] = 9'h1FF;
        dr[1] = 1'b1;
        #1;
        check("t34_acc", 32'(g[1].bus.src_ready), 1);
        check("t34_head", 32'(g[1].bus.dst_data_out), 32'h010);
        tick();
        fl[1] = 1'b0;
        sv[1] = 1'b0;
        #1;
        check("t34_occ0", 32'(g[1].bus.occupancy), 0);
        check("t34_vld0", 32'(g[1].bus.dst_vaild), 0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t34_gone", 32'(g[1].bus.dst_vaild), 0);
        end
        dr[1] = 1'b0;
        // backward mode, reset while the skid holds a word
        sv[2] = 1'b1;
        sd[2] = 9'h055;
        #1;
        check("t35_pass_rdy", 32'(g[2].bus.src_ready), 1);
        check("t35_pass_vld", 32'(g[2].bus.dst_vaild), 1);
        tick();
        sv[2] = 1'b0;
        #1;
        check("t35_skid_rdy", 32'(g[2].bus.src_ready), 0);
        check("t35_skid_vld", 32'(g[2].bus.dst_vaild), 1);
        check("t35_skid_data", 32'(g[2].bus.dst_data_out), 32'h055);
        check("t35_skid_occ", 32'(g[2].bus.occupancy), 1);
        s_rst = 1'b1;
        tick();
        s_rst = 1'b0;
        #1;
        check("t35_rst_vld", 32'(g[2].bus.dst_vaild), 0);
        check("t35_rst_occ", 32'(g[2].bus.occupancy), 0);
        check("t35_rst_rdy", 32'(g[2].bus.src_ready), 0);
        tick();
        check("t35_rdy_back", 32'(g[2].bus.src_ready), 1);
        // wire mode, every valid/ready combination
        for (int i = 0; i < 4; i++) begin
            sv[3] = i[0];
            dr[3] = i[1];
            sd[3] = 9'(i * 97 + 5);
            #1;
            check("t36_vld", 32'(g[3].bus.dst_vaild), i % 2);
            check("t36_rdy", 32'(g[3].bus.src_ready), i / 2);
            check("t36_data", 32'(g[3].bus.dst_data_out), i * 97 + 5);
            check("t36_occ", 32'(g[3].bus.occupancy), 0);
            tick();
        end
        sv[3] = 1'b0;
        dr[3] = 1'b0;
        // random traffic on all four, sources hold their word while stalled
        s_rst = 1'b1;
        repeat (2) tick();
        s_rst = 1'b0;
        rnd = 1'b1;
        c = 0;
        while (c < 20000 && (dn_a[0] < 1000 || dn_a[1] < 1000 || dn_a[2] < 1000 || dn_a[3] < 1000)) begin
            for (int k = 0; k < 4; k++) begin
                if (!stall_a[k]) begin
                    sv[k] = 1'($urandom_range(1));
                    sd[k] = 9'($urandom);
                end
                dr[k] = 1'($urandom_range(1));
            end
            tick();
            c++;
        end
        check("rnd_words", 32'(dn_a[0] >= 1000 && dn_a[1] >= 1000 && dn_a[2] >= 1000 && dn_a[3] >= 1000), 1);
        for (int k = 0; k < 4; k++) dr[k] = 1'b1;
        tick();
        for (int k = 0; k < 4; k++) sv[k] = 1'b0;
        repeat (20) tick();
        for (int k = 0; k < 4; k++) check("rnd_drained", pn_a[k], 0);
        rnd = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
